dpu_cmd_bridge: RTL and testbench
=================================

# dpu_cmd_bridge

Byte-stream-to-PIO bridge sitting directly upstream of `dpu_top`'s command port. It deframes 5-byte host command frames from an 8-bit valid/ready byte stream and issues them on `dpu_top`'s `cmd_valid`/`cmd_ready` handshake. It also serialises `dpu_top` responses plus `reload_req`/`done` events back to the host as tagged 2-byte records. This replaces the bench-side `send_cmd`/reload loop when the DPU is driven from a UART or DMA stream.

## Interface

**Parameters**
- `RSP_DEPTH`, default 8: record FIFO depth. Power of two, ≥2.
- `TIMEOUT`, default 1000000: inter-byte gap, in cycles, that aborts a partial frame. 0 disables the timeout.

**Ports**
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8: host command byte stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8: host record byte stream.
- `cmd_valid` out 1, `cmd_ready` in 1, `cmd_type` out 3, `cmd_addr` out 24, `cmd_data` out 8: to `dpu_top`.
- `rsp_valid` in 1, `rsp_data` in 8: single-cycle response pulse from `dpu_top`.
- `reload_req` in 1, `done` in 1, `current_layer` in 6: `dpu_top` status.
- `err_bad_hdr` out 8: saturating count of bad header bytes.
- `err_timeout` out 8: saturating count of aborted frames.
- `err_ovf` out 1: sticky flag, a record was dropped.
- `frame_busy` out 1: high when state ≠ HDR.

## Operation

**Deframer FSM.** States: HDR → A2 → A1 → A0 → DAT → ISSUE → HDR.
- `in_ready = (state != ISSUE)`. It is combinational from the state.
- A byte is accepted when `in_valid && in_ready`.
- HDR: header byte. Requires `in_data[7:3] == 5'b10101`; `cmd_type` is taken from `in_data[2:0]`.
  - Bad header: drop the byte, increment `err_bad_hdr` (saturates at 255), stay in HDR. This is how the deframer resyncs.
- A2, A1, A0: capture `cmd_addr[23:16]`, `[15:8]`, `[7:0]`.
- DAT: capture `cmd_data`.
- ISSUE: `cmd_valid=1`, with `cmd_type`/`cmd_addr`/`cmd_data` held stable. On `cmd_valid && cmd_ready`, go to HDR.
- Timeout: in A2/A1/A0/DAT, a gap counter counts cycles with no accepted byte and clears on each accepted byte. When it reaches TIMEOUT: go to HDR, discard the captured fields, increment `err_timeout` (saturating).
- ISSUE has no timeout. It waits indefinitely for `cmd_ready`.

**Record path.**
- The FIFO holds 16-bit records {tag, payload}:
  - Response: `0x52`, `rsp_data`.
  - Reload: `0x4C`, `{2'b00, current_layer}` sampled at the edge.
  - Done: `0x44`, `0x00`.
- `reload_req` and `done` are rising-edge detected using prev registers (reset 0) and set pending flags `rl_pend` / `dn_pend`.
- At most one push per cycle. Priority: response > `rl_pend` > `dn_pend`. A pending flag clears when its record is pushed.
- A response that arrives while the FIFO is full is dropped and sets `err_ovf`.
- Pending flags wait; they are never dropped.
- A new edge while the same flag is already pending merges into it and is not counted twice.
- Serialiser: when idle and the FIFO is non-empty, pop one record and present the tag. On handshake, present the payload. After the payload handshake it is idle again; a pop may occur in that same cycle, so records stream back-to-back.

## Timing

**Reset values.**
- `state`=HDR (so `in_ready`=1).
- `cmd_valid`=0; `cmd_type`/`cmd_addr`/`cmd_data`=0.
- `out_valid`=0, `out_data`=0.
- Error counters 0, `err_ovf`=0, `frame_busy`=0.
- FIFO empty; pending and prev flags 0.
- Reset asserted mid-frame or mid-ISSUE aborts the frame with no count, and drops any `cmd_valid` the next cycle.

**Latencies.**
- DAT byte accepted in cycle N → `cmd_valid`=1 in N+1 (earliest accept N+1).
- Handshake in cycle M → `cmd_valid`=0 and `in_ready`=1 in M+1; the next header can be accepted in M+1.
- `rsp_valid` in cycle N with the FIFO and serialiser empty → FIFO written at end of N, pop in N+1, `out_valid` with tag in N+2.
- `out_valid`/`out_data` hold until `out_ready`.

**Boundaries.**
- `rsp_valid` and a reload edge in the same cycle: the response is pushed and reload stays pending to the next cycle.
- FIFO full and popped in the same cycle: a push is allowed.
- `reload_req` already high out of reset produces one reload record.

## Test plan

- Frame A8 00 00 00 00 with `cmd_ready` held low 5 cycles → `cmd_type`=0, `cmd_addr`=0, `cmd_valid` high 6 cycles; `in_ready`=0 throughout ISSUE; one transfer.
- Frame AC 12 34 56 7F → `cmd_type`=4, `cmd_addr`=0x123456, `cmd_data`=0x7F; then bytes 00 FF → `err_bad_hdr`=2, no command issued.
- TIMEOUT=16, send AB 01 then idle 16 cycles → `err_timeout`=1, `frame_busy`=0; following frame AA 00 00 01 05 issues `cmd_type`=2 correctly.
- `rsp_valid` with `rsp_data`=0x9C, `out_ready`=1 → `out_data` 0x52 at N+2, 0x9C at N+3.
- `reload_req` rises with `current_layer`=7 together with a `rsp_valid` → records R,resp then L,0x07 in order; `done` rise → 44 00.
- `out_ready`=0, 9 responses with RSP_DEPTH=8 → `err_ovf`=1; draining yields exactly 8 records in order.

Source files
------------

// File: rtl/dpu_cmd_bridge.sv
// dpu_cmd_bridge
// Bridges a host byte stream to the dpu_top command port, and returns DPU
// responses and status events to the host as 2-byte {tag, payload} records.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready/in_data     host command bytes (5-byte frames)
//   out_valid/out_ready/out_data  host record bytes (tag then payload)
//   cmd_valid/cmd_ready/cmd_type/cmd_addr/cmd_data   command to dpu_top
//   rsp_valid/rsp_data            single-cycle response pulse from dpu_top
//   reload_req/done/current_layer dpu_top status inputs
//   err_bad_hdr, err_timeout      saturating error counters
//   err_ovf                       sticky: a response record was dropped
//   frame_busy                    deframer is mid-frame or issuing
module dpu_cmd_bridge #(
  parameter int unsigned RSP_DEPTH = 8,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_type,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        reload_req,
  input  logic        done,
  input  logic [5:0]  current_layer,
  output logic [7:0]  err_bad_hdr,
  output logic [7:0]  err_timeout,
  output logic        err_ovf,
  output logic        frame_busy
);

  typedef enum logic [2:0] {S_HDR, S_A2, S_A1, S_A0, S_DAT, S_ISSUE} state_e;

  localparam int unsigned GW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (TIMEOUT > 0) ? GW'(TIMEOUT - 1) : '0;
  localparam int unsigned AW = $clog2(RSP_DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW + 2)'(RSP_DEPTH);

  // ---------------------------------------------------------------- deframer
  state_e        state_q;
  logic [GW-1:0] gap_q;
  logic          cmd_valid_q;
  logic [2:0]    cmd_type_q;
  logic [23:0]   cmd_addr_q;
  logic [7:0]    cmd_data_q;
  logic [7:0]    bad_hdr_q;
  logic [7:0]    timeout_q;
  logic          accept;
  logic          gap_expire;

  assign in_ready   = (state_q != S_ISSUE);
  assign frame_busy = (state_q != S_HDR);
  assign accept     = in_valid && in_ready;
  // The final idle cycle is the one that would bring the gap count to TIMEOUT.
  assign gap_expire = (TIMEOUT != 0) && (gap_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      gap_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      bad_hdr_q   <= '0;
      timeout_q   <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (accept) begin
            if (in_data[7:3] == 5'b10101) begin
              cmd_type_q <= in_data[2:0];
              gap_q      <= '0;
              state_q    <= S_A2;
            end else if (bad_hdr_q != 8'hFF) begin
              // Bad headers are dropped; this is how the stream resyncs.
              bad_hdr_q <= bad_hdr_q + 8'd1;
            end
          end
        end
        S_A2, S_A1, S_A0, S_DAT: begin
          if (accept) begin
            gap_q <= '0;
            case (state_q)
              S_A2: begin
                cmd_addr_q[23:16] <= in_data;
                state_q           <= S_A1;
              end
              S_A1: begin
                cmd_addr_q[15:8] <= in_data;
                state_q          <= S_A0;
              end
              S_A0: begin
                cmd_addr_q[7:0] <= in_data;
                state_q         <= S_DAT;
              end
              default: begin
                cmd_data_q  <= in_data;
                cmd_valid_q <= 1'b1;
                state_q     <= S_ISSUE;
              end
            endcase
          end else if (gap_expire) begin
            state_q    <= S_HDR;
            gap_q      <= '0;
            cmd_type_q <= '0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            if (timeout_q != 8'hFF) begin
              timeout_q <= timeout_q + 8'd1;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign err_bad_hdr = bad_hdr_q;
  assign err_timeout = timeout_q;

  // ------------------------------------------------------------- record path
  logic [15:0]   fifo_mem [RSP_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]   arr_cnt;
  logic [AW+1:0] occ;
  logic          out_valid_q, phase_q;
  logic [7:0]    out_data_q, pay_q;
  logic          rl_prev_q, dn_prev_q, rl_pend_q, dn_pend_q, ovf_q;
  logic [5:0]    rl_layer_q;
  logic          rl_rise, dn_rise, rec_done, can_push, pop;
  logic          push_d, push_rl_d, push_dn_d;
  logic [15:0]   push_rec_d, rd_rec;

  assign rl_rise = reload_req && !rl_prev_q;
  assign dn_rise = done && !dn_prev_q;
  assign arr_cnt = wr_ptr_q - rd_ptr_q;
  // Occupancy counts the record held by the serialiser, so a slot is only
  // released once that record's payload byte has been taken.
  assign occ      = {1'b0, arr_cnt} + {{(AW + 1){1'b0}}, out_valid_q};
  assign rec_done = out_valid_q && out_ready && phase_q;
  assign can_push = (occ < DEPTH_V) || rec_done;
  assign pop      = (arr_cnt != '0) && (!out_valid_q || rec_done);
  assign rd_rec   = fifo_mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    push_d     = 1'b0;
    push_rl_d  = 1'b0;
    push_dn_d  = 1'b0;
    push_rec_d = '0;
    if (rsp_valid) begin
      push_d     = can_push;
      push_rec_d = {8'h52, rsp_data};
    end else if (rl_pend_q) begin
      push_d     = can_push;
      push_rl_d  = can_push;
      push_rec_d = {8'h4C, 2'b00, rl_layer_q};
    end else if (dn_pend_q) begin
      push_d     = can_push;
      push_dn_d  = can_push;
      push_rec_d = 16'h4400;
    end
  end

  always_ff @(posedge clk) begin
    if (push_d) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= push_rec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pay_q       <= '0;
      phase_q     <= 1'b0;
      rl_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      rl_pend_q   <= 1'b0;
      dn_pend_q   <= 1'b0;
      rl_layer_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rl_prev_q <= reload_req;
      dn_prev_q <= done;
      // A new edge while pending merges into the existing flag.
      if (rl_rise) begin
        rl_pend_q  <= 1'b1;
        rl_layer_q <= current_layer;
      end else if (push_rl_d) begin
        rl_pend_q <= 1'b0;
      end
      if (dn_rise) begin
        dn_pend_q <= 1'b1;
      end else if (push_dn_d) begin
        dn_pend_q <= 1'b0;
      end
      if (rsp_valid && !can_push) begin
        ovf_q <= 1'b1;
      end
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + (AW + 1)'(1);
        out_valid_q <= 1'b1;
        out_data_q  <= rd_rec[15:8];
        pay_q       <= rd_rec[7:0];
        phase_q     <= 1'b0;
      end else if (out_valid_q && out_ready) begin
        if (!phase_q) begin
          out_data_q <= pay_q;
          phase_q    <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_dpu_cmd_bridge.sv
// Directed bench for dpu_cmd_bridge (TIMEOUT=16, RSP_DEPTH=8). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_dpu_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_type;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        reload_req, done;
  logic [5:0]  current_layer;
  logic [7:0]  err_bad_hdr, err_timeout;
  logic        err_ovf, frame_busy;

  dpu_cmd_bridge #(.RSP_DEPTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .reload_req(reload_req), .done(done), .current_layer(current_layer),
    .err_bad_hdr(err_bad_hdr), .err_timeout(err_timeout),
    .err_ovf(err_ovf), .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bytes;
    logic [2:0]  typ;
    logic [23:0] addr;
    logic [7:0]  dat;
  } frame_vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int xfer_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  frame_vec_t vecs[4];

  // Host-side record collector and command transfer counter.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) rx_q.push_back(out_data);
    if (rst_n && cmd_valid && cmd_ready) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("check %-14s got %0h expected %0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called and returns just after a falling edge; bytes go back-to-back.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_byte: in_ready got 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    int x0;
    cmd_ready = 1'b1;
    for (int j = 0; j < 5; j++) send_byte(v.bytes[39-8*j -: 8]);
    x0 = xfer_cnt;
    chk("frm_valid", 32'(cmd_valid), 32'd1);
    chk("frm_type", 32'(cmd_type), 32'(v.typ));
    chk("frm_addr", 32'(cmd_addr), 32'(v.addr));
    chk("frm_data", 32'(cmd_data), 32'(v.dat));
    chk("frm_in_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("frm_valid_dn", 32'(cmd_valid), 32'd0);
    chk("frm_in_rdy_up", 32'(in_ready), 32'd1);
    chk("frm_xfer", 32'(xfer_cnt), 32'(x0 + 1));
  endtask

  task automatic wait_rx(input string name, input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk(name, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk(name, 32'(rx_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int hi, x0;
    vecs[0] = '{40'hAC1234567F, 3'd4, 24'h123456, 8'h7F};
    vecs[1] = '{40'hAFFFFFFFFF, 3'd7, 24'hFFFFFF, 8'hFF};
    vecs[2] = '{40'hA900010080, 3'd1, 24'h000100, 8'h80};
    vecs[3] = '{40'hAA00000105, 3'd2, 24'h000001, 8'h05};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    reload_req = 1'b0; done = 1'b0; current_layer = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_fields", {5'd0, cmd_type, cmd_addr}, 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_out", {23'd0, out_valid, out_data}, 32'd0);
    chk("rst_errs", {15'd0, err_ovf, err_timeout, err_bad_hdr}, 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);

    // Stalled issue: cmd_ready low 5 cycles, then one transfer.
    cmd_ready = 1'b0;
    x0 = xfer_cnt;
    send_byte(8'hA8); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_valid) hi++;
      chk("stall_in_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    if (cmd_valid) hi++;
    chk("stall_type", 32'(cmd_type), 32'd0);
    chk("stall_addr", 32'(cmd_addr), 32'd0);
    @(negedge clk);
    chk("stall_hi_cyc", 32'(hi), 32'd6);
    chk("stall_vdn", 32'(cmd_valid), 32'd0);
    chk("stall_in_rdy1", 32'(in_ready), 32'd1);
    chk("stall_xfer", 32'(xfer_cnt), 32'(x0 + 1));

    // Table-driven frames
    for (int v = 0; v < 3; v++) run_frame(vecs[v]);

    // Bad headers: dropped and counted, no command.
    x0 = xfer_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    chk("bad_hdr2", 32'(err_bad_hdr), 32'd2);
    chk("bad_busy", 32'(frame_busy), 32'd0);
    send_byte(8'hB5);
    chk("bad_hdr3", 32'(err_bad_hdr), 32'd3);
    chk("bad_noxfer", 32'(xfer_cnt), 32'(x0));

    // Inter-byte timeout after AB 01
    send_byte(8'hAB); send_byte(8'h01);
    chk("to_busy0", 32'(frame_busy), 32'd1);
    repeat (15) @(negedge clk);
    chk("to_busy15", 32'(frame_busy), 32'd1);
    chk("to_cnt15", 32'(err_timeout), 32'd0);
    @(negedge clk);
    chk("to_busy16", 32'(frame_busy), 32'd0);
    chk("to_cnt16", 32'(err_timeout), 32'd1);
    run_frame(vecs[3]);

    // Response latency: tag at N+2, payload at N+3.
    rsp_valid = 1'b1; rsp_data = 8'h9C;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("rsp_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rsp_n2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h52});
    @(negedge clk);
    chk("rsp_n3", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h9C});
    @(negedge clk);
    chk("rsp_n4_valid", 32'(out_valid), 32'd0);

    // Response + reload edge together, then done.
    rx_q.delete();
    reload_req = 1'b1; current_layer = 6'd7; rsp_valid = 1'b1; rsp_data = 8'h3C;
    @(negedge clk);
    rsp_valid = 1'b0;
    repeat (6) @(negedge clk);
    done = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'h52); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h07);
    exp_q.push_back(8'h44); exp_q.push_back(8'h00);
    wait_rx("evt_rx", 6);
    reload_req = 1'b0; done = 1'b0;
    @(negedge clk);

    // Overflow: 9 responses against 8 record slots with out_ready low.
    rx_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ovf_before", 32'(err_ovf), 32'd0);
      rsp_valid = 1'b1; rsp_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    chk("ovf_after", 32'(err_ovf), 32'd1);
    // Still full during tag handshake: this response must be dropped.
    out_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 8'hEE;
    @(negedge clk);
    // Payload handshake frees a slot in this cycle: push is accepted.
    rsp_data = 8'h19;
    @(negedge clk);
    rsp_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h52); exp_q.push_back(8'(8'h10 + i));
    end
    exp_q.push_back(8'h52); exp_q.push_back(8'h19);
    wait_rx("ovf_rx", 18);

    // Bad-header counter saturates.
    for (int i = 0; i < 254; i++) send_byte(8'h00);
    chk("bad_sat", 32'(err_bad_hdr), 32'd255);

    // Reset mid-issue, with reload_req already high coming out of reset.
    cmd_ready = 1'b0;
    send_byte(8'hA8); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    chk("mid_valid", 32'(cmd_valid), 32'd1);
    chk("mid_addr", 32'(cmd_addr), 32'h010203);
    reload_req = 1'b1; current_layer = 6'h2A; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(cmd_valid), 32'd0);
    chk("mrst_in_rdy", 32'(in_ready), 32'd1);
    chk("mrst_busy", 32'(frame_busy), 32'd0);
    chk("mrst_errs", {15'd0, err_ovf, err_timeout, err_bad_hdr}, 32'd0);
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h4C); exp_q.push_back(8'h2A);
    wait_rx("rst_rl_rx", 2);
    repeat (10) @(negedge clk);
    chk("rst_rl_once", 32'(rx_q.size()), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
